// File: rtl/sram_fifo_pkg.sv
// Shared defaults, macro control encoding and helpers for the SRAM-backed FIFO controller.
// Macro controls are active-low; the helpers build a port's control word from an enable.
package sram_fifo_pkg;

   localparam int DEPTH_DEF    = 32;
   localparam int WIDTH_DEF    = 4;
   localparam int ADDR_W_DEF   = 5;
   localparam int MACRO_RD_LAT = 1;
   localparam int OUTBUF_DEPTH = 2;

   typedef struct packed {
      logic csb;
      logic web;
      logic oeb;
   } sram_ctrl_t;

   localparam sram_ctrl_t SRAM_IDLE = '{csb: 1'b1, web: 1'b1, oeb: 1'b1};

   // Write-only port: output enable stays deasserted.
   function automatic sram_ctrl_t mk_wr_ctrl(input logic en);
      sram_ctrl_t c;
      c.csb = ~en;
      c.web = ~en;
      c.oeb = 1'b1;
      return c;
   endfunction

   // Read-only port: write enable stays deasserted.
   function automatic sram_ctrl_t mk_rd_ctrl(input logic en);
      sram_ctrl_t c;
      c.csb = ~en;
      c.web = 1'b1;
      c.oeb = ~en;
      return c;
   endfunction

endpackage

// File: rtl/sram_fifo_outbuf.sv
// Two-entry output FIFO that absorbs words returning from the macro read port.
// Push and pop may coincide; a push while full is only honoured alongside a pop.
module sram_fifo_outbuf
   import sram_fifo_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             i_clock,
   input  logic             i_reset_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_push_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_head,
   output logic [1:0]       o_cnt
);

   logic [WIDTH-1:0] r_mem [OUTBUF_DEPTH];
   logic             r_rd_idx;
   logic             r_wr_idx;
   logic [1:0]       r_cnt;
   logic             w_pop;
   logic             w_push;

   assign w_pop  = i_pop & (r_cnt != 2'd0);
   assign w_push = i_push & ((r_cnt != 2'd2) | w_pop);

   always_ff @(posedge i_clock) begin
      if (!i_reset_n) begin
         r_rd_idx <= 1'b0;
         r_wr_idx <= 1'b0;
         r_cnt    <= 2'd0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_idx] <= i_push_data;
            r_wr_idx        <= ~r_wr_idx;
         end
         if (w_pop) begin
            r_rd_idx <= ~r_rd_idx;
         end
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + 2'd1;
            2'b01:   r_cnt <= r_cnt - 2'd1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   assign o_head = r_mem[r_rd_idx];
   assign o_cnt  = r_cnt;

endmodule

// File: rtl/sram_fifo_ctrl.sv
// Valid/ready FIFO built on a 2RW SRAM macro: port 1 writes, port 2 reads, and a
// two-entry output buffer hides the registered read latency for full-rate streaming.
module sram_fifo_ctrl
   import sram_fifo_pkg::*;
#(
   parameter int DEPTH  = DEPTH_DEF,
   parameter int WIDTH  = WIDTH_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  out_data,
   output logic [ADDR_W+1:0] count,
   output logic [ADDR_W-1:0] sram_a1,
   output logic [WIDTH-1:0]  sram_i1,
   output logic              sram_csb1,
   output logic              sram_web1,
   output logic              sram_oeb1,
   output logic [ADDR_W-1:0] sram_a2,
   output logic              sram_csb2,
   output logic              sram_web2,
   output logic              sram_oeb2,
   input  logic [WIDTH-1:0]  sram_o2
);

   localparam int CNT_W = ADDR_W + 1;
   localparam int OCC_W = ADDR_W + 2;
   localparam logic [CNT_W-1:0] MEM_FULL = CNT_W'(DEPTH);

   logic [ADDR_W-1:0] r_wr_ptr;
   logic [ADDR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0]  r_mem_count;
   logic              r_inflight;

   logic              w_in_ready;
   logic              w_enq;
   logic              w_out_valid;
   logic              w_deq;
   logic              w_issue;
   logic [1:0]        w_out_cnt;
   logic [2:0]        w_pend;
   sram_ctrl_t        w_p1;
   sram_ctrl_t        w_p2;

   assign w_in_ready  = (r_mem_count != MEM_FULL) & reset_n;
   assign w_enq       = in_valid & w_in_ready;
   assign w_out_valid = (w_out_cnt != 2'd0) & reset_n;
   assign w_deq       = w_out_valid & out_ready;
   assign w_pend      = {1'b0, w_out_cnt} + {2'b00, r_inflight};

   // Reads only consume words already counted in r_mem_count, so a word written
   // this cycle can never be read from the same address in the same cycle.
   assign w_issue = reset_n & (r_mem_count != '0) & ((w_pend < 3'd2) | w_deq);

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_mem_count <= '0;
         r_inflight  <= 1'b0;
      end else begin
         if (w_enq) begin
            r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
         end
         if (w_issue) begin
            r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
         end
         case ({w_enq, w_issue})
            2'b10:   r_mem_count <= r_mem_count + CNT_W'(1);
            2'b01:   r_mem_count <= r_mem_count - CNT_W'(1);
            default: r_mem_count <= r_mem_count;
         endcase
         r_inflight <= w_issue;
      end
   end

   sram_fifo_outbuf #(
      .WIDTH (WIDTH)
   ) u_outbuf (
      .i_clock     (clock),
      .i_reset_n   (reset_n),
      .i_push      (r_inflight),
      .i_push_data (sram_o2),
      .i_pop       (w_deq),
      .o_head      (out_data),
      .o_cnt       (w_out_cnt)
   );

   assign w_p1 = mk_wr_ctrl(w_enq);
   assign w_p2 = mk_rd_ctrl(w_issue);

   assign sram_a1   = r_wr_ptr;
   assign sram_i1   = in_data;
   assign sram_csb1 = w_p1.csb;
   assign sram_web1 = w_p1.web;
   assign sram_oeb1 = w_p1.oeb;

   assign sram_a2   = r_rd_ptr;
   assign sram_csb2 = w_p2.csb;
   assign sram_web2 = w_p2.web;
   assign sram_oeb2 = w_p2.oeb;

   assign in_ready  = w_in_ready;
   assign out_valid = w_out_valid;
   assign count     = {1'b0, r_mem_count} + OCC_W'(r_inflight) + OCC_W'(w_out_cnt);

   // Output buffer plus the read in flight must always fit in the two buffer slots.
   a_outbuf_room: assert property (@(posedge clock) disable iff (!reset_n)
      (w_pend <= 3'd2));

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Bench for sram_fifo_ctrl with a behavioural 2RW macro beside it; a forked monitor
// scores every handshake against a queue while directed sequences check timing.
module tb_sram_fifo_ctrl;

   localparam int DEPTH  = 32;
   localparam int WIDTH  = 4;
   localparam int ADDR_W = 5;

   logic              clock;
   logic              reset_n;
   logic              in_valid;
   logic              in_ready;
   logic [WIDTH-1:0]  in_data;
   logic              out_valid;
   logic              out_ready;
   logic [WIDTH-1:0]  out_data;
   logic [ADDR_W+1:0] count;
   logic [ADDR_W-1:0] sram_a1;
   logic [WIDTH-1:0]  sram_i1;
   logic              sram_csb1, sram_web1, sram_oeb1;
   logic [ADDR_W-1:0] sram_a2;
   logic              sram_csb2, sram_web2, sram_oeb2;
   logic [WIDTH-1:0]  sram_o2;

   logic [WIDTH-1:0]  macro_mem [DEPTH];

   int                n_tests;
   int                n_fail;
   logic [WIDTH-1:0]  sb [$];
   bit                armed;
   bit                wrap1;
   bit                wrap2;
   int                n_deq;

   sram_fifo_ctrl #(
      .DEPTH  (DEPTH),
      .WIDTH  (WIDTH),
      .ADDR_W (ADDR_W)
   ) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .count     (count),
      .sram_a1   (sram_a1),
      .sram_i1   (sram_i1),
      .sram_csb1 (sram_csb1),
      .sram_web1 (sram_web1),
      .sram_oeb1 (sram_oeb1),
      .sram_a2   (sram_a2),
      .sram_csb2 (sram_csb2),
      .sram_web2 (sram_web2),
      .sram_oeb2 (sram_oeb2),
      .sram_o2   (sram_o2)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Macro model: registered read, data valid the cycle after the read is issued.
   always @(posedge clock) begin
      if (!sram_csb1 && !sram_web1) macro_mem[sram_a1] <= sram_i1;
      if (!sram_csb2 && !sram_oeb2) sram_o2 <= macro_mem[sram_a2];
   end

   task automatic chk(input bit ok, input string name, input int act, input int exp);
      n_tests++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic monitor_loop();
      logic [ADDR_W-1:0] exp_wa;
      logic [ADDR_W-1:0] exp_ra;
      logic [ADDR_W-1:0] last_a1;
      logic [ADDR_W-1:0] last_a2;
      logic [WIDTH-1:0]  e;
      bit                enq;
      exp_wa = '0; exp_ra = '0; last_a1 = '0; last_a2 = '0;
      forever begin
         @(negedge clock);
         if (!reset_n) begin
            chk(in_ready === 1'b0 && out_valid === 1'b0, "rst_hs",
                int'({in_ready, out_valid}), 0);
            chk(sram_csb1 === 1'b1 && sram_csb2 === 1'b1, "rst_csb",
                int'({sram_csb1, sram_csb2}), 3);
            sb.delete();
            exp_wa = '0;
            exp_ra = '0;
            armed  = 1'b1;
         end else if (armed) begin
            chk(count === 7'(sb.size()), "count", int'(count), sb.size());
            chk(sram_oeb1 === 1'b1 && sram_web2 === 1'b1, "fixed_ctrl",
                int'({sram_oeb1, sram_web2}), 3);
            enq = in_valid && in_ready;
            chk(sram_csb1 === !enq, "csb1_enq", int'(sram_csb1), int'(!enq));
            if (enq) begin
               chk(sram_a1 === exp_wa, "a1", int'(sram_a1), int'(exp_wa));
               if (last_a1 == 5'd31 && sram_a1 == 5'd0) wrap1 = 1'b1;
               last_a1 = sram_a1;
               exp_wa  = exp_wa + 5'd1;
               sb.push_back(in_data);
            end
            if (sram_csb2 === 1'b0) begin
               chk(sram_a2 === exp_ra, "a2", int'(sram_a2), int'(exp_ra));
               if (last_a2 == 5'd31 && sram_a2 == 5'd0) wrap2 = 1'b1;
               last_a2 = sram_a2;
               exp_ra  = exp_ra + 5'd1;
               if (sram_csb1 === 1'b0)
                  chk(sram_a1 !== sram_a2, "collision", int'(sram_a1), int'(sram_a2));
            end
            if (out_valid && out_ready) begin
               n_deq++;
               if (sb.size() == 0) begin
                  chk(1'b0, "underflow", int'(out_data), -1);
               end else begin
                  e = sb.pop_front();
                  chk(out_data === e, "data", int'(out_data), int'(e));
               end
            end
         end
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   initial begin
      int ov [4];
      int cv [4];
      int exp_ov [4];
      int exp_cv [4];
      int acc, sent, first, last, cyc, d0;
      bit a, done;

      n_tests = 0; n_fail = 0; armed = 1'b0; wrap1 = 1'b0; wrap2 = 1'b0; n_deq = 0;
      reset_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      fork
         monitor_loop();
      join_none
      repeat (3) @(posedge clock);
      #1 reset_n = 1'b1;

      // Single word latency
      exp_ov = '{0, 0, 1, 0};
      exp_cv = '{1, 1, 1, 0};
      out_ready = 1'b1; in_valid = 1'b1; in_data = 4'hA;
      @(negedge clock);
      chk(in_ready === 1'b1, "lat_rdy", int'(in_ready), 1);
      step();
      in_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clock);
         ov[k] = int'(out_valid);
         cv[k] = int'(count);
         if (k == 2) chk(out_data === 4'hA, "lat_data", int'(out_data), 10);
      end
      for (int k = 0; k < 4; k++) begin
         chk(ov[k] == exp_ov[k], "lat_ov", ov[k], exp_ov[k]);
         chk(cv[k] == exp_cv[k], "lat_cnt", cv[k], exp_cv[k]);
      end

      // Fill to 34 with no consumer, then drain
      step();
      out_ready = 1'b0; in_valid = 1'b1; in_data = 4'h0; acc = 0;
      for (cyc = 0; cyc < 200 && acc < 34; cyc++) begin
         @(negedge clock);
         a = in_valid && in_ready;
         step();
         if (a) begin
            acc++;
            in_data = 4'(acc);
         end
      end
      chk(acc == 34, "fill_acc", acc, 34);
      for (int k = 0; k < 5; k++) begin
         @(negedge clock);
         chk(in_ready === 1'b0, "fill_rdy", int'(in_ready), 0);
         chk(count === 7'd34, "fill_cnt", int'(count), 34);
      end
      step();
      in_valid = 1'b0; out_ready = 1'b1; d0 = n_deq;
      for (cyc = 0; cyc < 200 && sb.size() != 0; cyc++) step();
      chk(n_deq - d0 == 34, "drain_n", n_deq - d0, 34);

      // Full-rate stream of 100 words
      repeat (3) step();
      in_valid = 1'b1; in_data = 4'h0; sent = 0; first = -1; last = -1; d0 = n_deq;
      for (cyc = 0; cyc < 300 && (n_deq - d0) < 100; cyc++) begin
         @(negedge clock);
         a = in_valid && in_ready;
         if (out_valid && out_ready) begin
            if (first < 0) first = cyc;
            last = cyc;
         end
         step();
         if (a) begin
            sent++;
            in_data = 4'(sent * 3);
            if (sent == 100) in_valid = 1'b0;
         end
      end
      chk(first == 3, "stream_first", first, 3);
      chk(last - first + 1 == 100, "stream_span", last - first + 1, 100);

      // Random consumer backpressure over 500 words
      repeat (3) step();
      in_valid = 1'b1; in_data = 4'h5; sent = 0; d0 = n_deq; done = 1'b0;
      for (cyc = 0; cyc < 5000 && !done; cyc++) begin
         out_ready = 1'($urandom_range(0, 1));
         @(negedge clock);
         a = in_valid && in_ready;
         step();
         if (a) begin
            sent++;
            in_data = 4'(sent ^ (sent >> 4));
            if (sent == 500) in_valid = 1'b0;
         end
         done = (n_deq - d0) == 500;
      end
      chk(n_deq - d0 == 500, "rand_n", n_deq - d0, 500);
      out_ready = 1'b1;
      repeat (4) step();

      // Pointer wrap with single enq/deq pairs
      wrap1 = 1'b0; wrap2 = 1'b0; d0 = n_deq;
      for (int i = 0; i < 40; i++) begin
         in_valid = 1'b1; in_data = 4'(i * 7);
         for (cyc = 0; cyc < 20; cyc++) begin
            @(negedge clock);
            a = in_ready;
            step();
            if (a) break;
         end
         in_valid = 1'b0;
         for (cyc = 0; cyc < 20 && (n_deq - d0) <= i; cyc++) step();
      end
      chk(n_deq - d0 == 40, "wrap_n", n_deq - d0, 40);
      chk(wrap1, "wrap1", int'(wrap1), 1);
      chk(wrap2, "wrap2", int'(wrap2), 1);

      // Reset while a read is in flight
      out_ready = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_data = 4'(i + 9);
         step();
      end
      in_valid = 1'b0;
      repeat (6) step();
      chk(count === 7'd5, "pre_rst_cnt", int'(count), 5);
      out_ready = 1'b1;
      @(negedge clock);
      chk(out_valid === 1'b1 && sram_csb2 === 1'b0, "pre_rst_issue",
          int'({out_valid, sram_csb2}), 2);
      step();
      out_ready = 1'b0; reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      @(negedge clock);
      chk(out_valid === 1'b0, "rst_ov", int'(out_valid), 0);
      chk(count === 7'd0, "rst_cnt", int'(count), 0);
      chk(sram_csb2 === 1'b1, "rst_csb2", int'(sram_csb2), 1);
      step();
      in_valid = 1'b1; in_data = 4'h3; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      done = 1'b0;
      for (cyc = 0; cyc < 20 && !done; cyc++) begin
         @(negedge clock);
         if (out_valid) begin
            chk(out_data === 4'h3, "post_rst_data", int'(out_data), 3);
            done = 1'b1;
         end
         step();
      end
      chk(done, "post_rst_timeout", int'(done), 1);
      repeat (3) step();
      chk(sb.size() == 0, "end_empty", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
